// File: rtl/mem_stage_if.sv
// Data-bus interface between the load/store unit (master) and memory (slave).
// Request/grant for the address phase, rvalid for load return data.
interface mem_stage_if #(
   parameter int unsigned XLEN = 64
);
   logic            req;
   logic            we;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] wdata;
   logic [7:0]      wmask;
   logic            gnt;
   logic            rvalid;
   logic [XLEN-1:0] rdata;

   modport master (
      output req, we, addr, wdata, wmask,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata, wmask,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/mem_stage.sv
// Load/store unit: one bus transaction per memory instruction, byte-lane alignment,
// load sign/zero extension, and a stall until the access retires.
module mem_stage #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_valid_i,
   input  logic             mem_wr_i,
   input  logic [2:0]       funct3_i,
   input  logic [XLEN-1:0]  addr_i,
   input  logic [XLEN-1:0]  wdata_i,
   input  logic [4:0]       rd_addr_i,
   output logic             stall_o,
   output logic             rd_w_ena_o,
   output logic [4:0]       rd_w_addr_o,
   output logic [XLEN-1:0]  rd_data_o,
   output logic             err_o,
   mem_stage_if.master      dbus
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [2:0]        addr_lo_q, addr_lo_d;
   logic [4:0]        rd_q, rd_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [XLEN-1:0]   baddr_q, baddr_d;
   logic [XLEN-1:0]   bwdata_q, bwdata_d;
   logic [7:0]        wmask_q, wmask_d;
   logic              rd_w_ena_q, rd_w_ena_d;
   logic [4:0]        rd_w_addr_q, rd_w_addr_d;
   logic [XLEN-1:0]   rd_data_q, rd_data_d;
   logic              err_q, err_d;

   logic [7:0]        size_mask_c;
   logic [2:0]        align_mask_c;
   logic              bad_c;
   logic              timeout_c;
   logic [XLEN-1:0]   ld_sh_c;
   logic [XLEN-1:0]   ld_ext_c;

   // Access size decode and alignment/legality check on the incoming request
   always_comb begin
      size_mask_c  = 8'h01;
      align_mask_c = 3'b000;
      case (funct3_i[1:0])
         2'b00: begin size_mask_c = 8'h01; align_mask_c = 3'b000; end
         2'b01: begin size_mask_c = 8'h03; align_mask_c = 3'b001; end
         2'b10: begin size_mask_c = 8'h0F; align_mask_c = 3'b011; end
         default: begin size_mask_c = 8'hFF; align_mask_c = 3'b111; end
      endcase
      bad_c = (funct3_i == 3'b111) || ((addr_i[2:0] & align_mask_c) != 3'b000);
   end

   assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));

   // Shift the addressed lanes down to bit 0, then extend per access type
   always_comb begin
      ld_sh_c  = dbus.rdata >> {addr_lo_q, 3'b000};
      ld_ext_c = ld_sh_c;
      case (funct3_q)
         3'b000: ld_ext_c = {{(XLEN-8){ld_sh_c[7]}},   ld_sh_c[7:0]};
         3'b001: ld_ext_c = {{(XLEN-16){ld_sh_c[15]}}, ld_sh_c[15:0]};
         3'b010: ld_ext_c = {{(XLEN-32){ld_sh_c[31]}}, ld_sh_c[31:0]};
         3'b100: ld_ext_c = {{(XLEN-8){1'b0}},         ld_sh_c[7:0]};
         3'b101: ld_ext_c = {{(XLEN-16){1'b0}},        ld_sh_c[15:0]};
         3'b110: ld_ext_c = {{(XLEN-32){1'b0}},        ld_sh_c[31:0]};
         default: ld_ext_c = ld_sh_c;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      funct3_d    = funct3_q;
      addr_lo_d   = addr_lo_q;
      rd_d        = rd_q;
      req_d       = 1'b0;
      we_d        = we_q;
      baddr_d     = baddr_q;
      bwdata_d    = bwdata_q;
      wmask_d     = wmask_q;
      rd_w_ena_d  = 1'b0;
      rd_w_addr_d = rd_w_addr_q;
      rd_data_d   = rd_data_q;
      err_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (mem_valid_i) begin
               wr_d      = mem_wr_i;
               funct3_d  = funct3_i;
               addr_lo_d = addr_i[2:0];
               rd_d      = rd_addr_i;
               if (bad_c) begin
                  state_d = S_RESP;
                  err_d   = 1'b1;
               end else begin
                  state_d  = S_REQ;
                  cnt_d    = '0;
                  req_d    = 1'b1;
                  we_d     = mem_wr_i;
                  baddr_d  = {addr_i[XLEN-1:3], 3'b000};
                  bwdata_d = wdata_i << {addr_i[2:0], 3'b000};
                  wmask_d  = size_mask_c << addr_i[2:0];
               end
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (dbus.gnt) begin
               state_d = wr_q ? S_RESP : S_WAIT;
            end else if (timeout_c) begin
               state_d = S_RESP;
               err_d   = 1'b1;
            end else begin
               req_d = 1'b1;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (dbus.rvalid) begin
               state_d     = S_RESP;
               rd_data_d   = ld_ext_c;
               rd_w_addr_d = rd_q;
               rd_w_ena_d  = (rd_q != 5'd0);
            end else if (timeout_c) begin
               state_d = S_RESP;
               err_d   = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         wr_q        <= 1'b0;
         funct3_q    <= 3'b000;
         addr_lo_q   <= 3'b000;
         rd_q        <= 5'd0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         baddr_q     <= '0;
         bwdata_q    <= '0;
         wmask_q     <= 8'h00;
         rd_w_ena_q  <= 1'b0;
         rd_w_addr_q <= 5'd0;
         rd_data_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         funct3_q    <= funct3_d;
         addr_lo_q   <= addr_lo_d;
         rd_q        <= rd_d;
         req_q       <= req_d;
         we_q        <= we_d;
         baddr_q     <= baddr_d;
         bwdata_q    <= bwdata_d;
         wmask_q     <= wmask_d;
         rd_w_ena_q  <= rd_w_ena_d;
         rd_w_addr_q <= rd_w_addr_d;
         rd_data_q   <= rd_data_d;
         err_q       <= err_d;
      end
   end

   // Stall must rise in the same cycle the instruction arrives, so it decodes the live input
   assign stall_o     = ((state_q == S_IDLE) && mem_valid_i) ||
                        (state_q == S_REQ) || (state_q == S_WAIT);
   assign rd_w_ena_o  = rd_w_ena_q;
   assign rd_w_addr_o = rd_w_addr_q;
   assign rd_data_o   = rd_data_q;
   assign err_o       = err_q;

   assign dbus.req   = req_q;
   assign dbus.we    = we_q;
   assign dbus.addr  = baddr_q;
   assign dbus.wdata = bwdata_q;
   assign dbus.wmask = wmask_q;

endmodule
